// File: rtl/lc3_pkg.sv
// Shared LC-3 control definitions: FSM states, opcodes and mux encodings.
// datapath imports this same package so both sides agree on select codes.
package lc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR_CHK,
        S_BR_TAKE,
        S_JMP,
        S_JSR1,
        S_JSR2,
        S_LDR1,
        S_LDR2,
        S_LDR3,
        S_STR1,
        S_STR2,
        S_STR3,
        S_PAUSE1,
        S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    // States that hold an SRAM strobe low for the wait count.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that times how long an SRAM strobe is held.
// done is high when the count reads 0, i.e. on the last strobe cycle.
module mem_wait_counter #(
    parameter int MEM_WAIT = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done
);

    localparam logic [3:0] LOAD_VAL = 4'(MEM_WAIT - 1);

    logic [3:0] r_count;

    // Load on entry to a memory state, then count down to the terminal count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_done = (r_count == 4'd0);

endmodule

// File: rtl/lc3_control.sv
// LC-3 instruction-sequencing control unit (Moore FSM driving datapath).
//
// state     | meaning
// HALTED    | idle until Run
// FETCH1    | MAR <- PC, PC <- PC+1
// FETCH2    | SRAM read (Mem_OE low), MDR loaded on last wait cycle
// FETCH3    | IR <- MDR
// DECODE    | latch BEN, dispatch on opcode
// ADD/AND/NOT | ALU op into DR, set CC
// BR_CHK    | test BEN
// BR_TAKE   | PC <- PC + off9
// JMP       | PC <- BaseR
// JSR1/JSR2 | R7 <- PC, then PC <- PC + off11 or BaseR
// LDR1..3   | MAR <- BaseR + off6, SRAM read, DR <- MDR
// STR1..3   | MAR <- BaseR + off6, MDR <- SR, SRAM write (Mem_WE low)
// PAUSE1/2  | show LED, wait for Continue press then release
module lc3_control
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic        MARMUX,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    state_t r_state;
    state_t w_next;
    logic   w_wait_done;
    logic   w_wait_load;
    logic   w_unused_ir;

    // Only opcode, IR[11] and IR[5] steer control; the rest belongs to datapath.
    assign w_unused_ir = ^{IR[10:6], IR[4:0]};

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_HALTED;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter restarts only when stepping into a memory state from elsewhere.
    assign w_wait_load = is_mem_state(w_next) && (w_next != r_state);

    mem_wait_counter #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_load  (w_wait_load),
        .i_dec   (is_mem_state(r_state)),
        .o_done  (w_wait_done)
    );

    // Next state and outputs; Reset forces the idle defaults in the same cycle
    // so a strobe or LD_MDR never survives into a reset cycle.
    always_comb begin
        w_next     = r_state;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_PC1;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALUK_ADD;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        MARMUX     = 1'b0;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;

        if (!Reset) begin
            case (r_state)
                S_HALTED: begin
                    if (Run) w_next = S_FETCH1;
                end
                S_FETCH1: begin
                    GatePC = 1'b1;
                    LD_MAR = 1'b1;
                    PCMUX  = PCMUX_PC1;
                    LD_PC  = 1'b1;
                    w_next = S_FETCH2;
                end
                S_FETCH2: begin
                    Mem_OE = 1'b0;
                    if (w_wait_done) begin
                        MIO_EN = 1'b1;
                        LD_MDR = 1'b1;
                        w_next = S_FETCH3;
                    end
                end
                S_FETCH3: begin
                    GateMDR = 1'b1;
                    LD_IR   = 1'b1;
                    w_next  = S_DECODE;
                end
                S_DECODE: begin
                    LD_BEN = 1'b1;
                    case (IR[15:12])
                        OP_ADD:   w_next = S_ADD;
                        OP_AND:   w_next = S_AND;
                        OP_NOT:   w_next = S_NOT;
                        OP_BR:    w_next = S_BR_CHK;
                        OP_JMP:   w_next = S_JMP;
                        OP_JSR:   w_next = S_JSR1;
                        OP_LDR:   w_next = S_LDR1;
                        OP_STR:   w_next = S_STR1;
                        OP_PAUSE: w_next = S_PAUSE1;
                        default:  w_next = S_FETCH1;
                    endcase
                end
                S_ADD, S_AND, S_NOT: begin
                    SR1MUX  = 1'b1;
                    SR2MUX  = IR[5];
                    ALUK    = (r_state == S_ADD) ? ALUK_ADD :
                              (r_state == S_AND) ? ALUK_AND : ALUK_NOT;
                    GateALU = 1'b1;
                    LD_REG  = 1'b1;
                    LD_CC   = 1'b1;
                    w_next  = S_FETCH1;
                end
                S_BR_CHK: begin
                    w_next = BEN ? S_BR_TAKE : S_FETCH1;
                end
                S_BR_TAKE: begin
                    ADDR2MUX = ADDR2_OFF9;
                    PCMUX    = PCMUX_ADDER;
                    LD_PC    = 1'b1;
                    w_next   = S_FETCH1;
                end
                S_JMP: begin
                    ADDR1MUX = 1'b1;
                    PCMUX    = PCMUX_ADDER;
                    LD_PC    = 1'b1;
                    w_next   = S_FETCH1;
                end
                S_JSR1: begin
                    GatePC = 1'b1;
                    DRMUX  = 1'b1;
                    LD_REG = 1'b1;
                    w_next = S_JSR2;
                end
                S_JSR2: begin
                    PCMUX = PCMUX_ADDER;
                    LD_PC = 1'b1;
                    if (IR[11]) begin
                        ADDR2MUX = ADDR2_OFF11;
                    end else begin
                        ADDR1MUX = 1'b1;
                    end
                    w_next = S_FETCH1;
                end
                S_LDR1, S_STR1: begin
                    ADDR1MUX   = 1'b1;
                    ADDR2MUX   = ADDR2_OFF6;
                    GateMARMUX = 1'b1;
                    LD_MAR     = 1'b1;
                    w_next     = (r_state == S_LDR1) ? S_LDR2 : S_STR2;
                end
                S_LDR2: begin
                    Mem_OE = 1'b0;
                    if (w_wait_done) begin
                        MIO_EN = 1'b1;
                        LD_MDR = 1'b1;
                        w_next = S_LDR3;
                    end
                end
                S_LDR3: begin
                    GateMDR = 1'b1;
                    LD_REG  = 1'b1;
                    LD_CC   = 1'b1;
                    w_next  = S_FETCH1;
                end
                S_STR2: begin
                    ALUK    = ALUK_PASSA;
                    GateALU = 1'b1;
                    LD_MDR  = 1'b1;
                    w_next  = S_STR3;
                end
                S_STR3: begin
                    Mem_WE = 1'b0;
                    if (w_wait_done) w_next = S_FETCH1;
                end
                S_PAUSE1: begin
                    LD_LED = 1'b1;
                    if (Continue) w_next = S_PAUSE2;
                end
                S_PAUSE2: begin
                    if (!Continue) w_next = S_FETCH1;
                end
                default: w_next = S_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_control.sv
// Self-checking bench for lc3_control: two instances (MEM_WAIT 2 and 3),
// table-driven instruction vectors, directed corner sequences and random
// instructions checked against a cycle-accounting reference model.
module tb_lc3_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset [2];
    logic        run   [2];
    logic        cont  [2];
    logic        ben   [2];
    logic [15:0] ir    [2];

    logic       ld_mar[2], ld_mdr[2], ld_ir[2], ld_ben[2], ld_cc[2], ld_reg[2], ld_pc[2], ld_led[2];
    logic       gate_pc[2], gate_mdr[2], gate_alu[2], gate_marmux[2];
    logic [1:0] pcmux[2], addr2mux[2], aluk[2];
    logic       drmux[2], sr1mux[2], sr2mux[2], addr1mux[2], marmux[2], mio_en[2], mem_oe[2], mem_we[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lc3_control #(.MEM_WAIT(g == 0 ? 2 : 3)) u_dut (
            .Clk(clk), .Reset(reset[g]), .Run(run[g]), .Continue(cont[g]),
            .IR(ir[g]), .BEN(ben[g]),
            .LD_MAR(ld_mar[g]), .LD_MDR(ld_mdr[g]), .LD_IR(ld_ir[g]), .LD_BEN(ld_ben[g]),
            .LD_CC(ld_cc[g]), .LD_REG(ld_reg[g]), .LD_PC(ld_pc[g]), .LD_LED(ld_led[g]),
            .GatePC(gate_pc[g]), .GateMDR(gate_mdr[g]), .GateALU(gate_alu[g]),
            .GateMARMUX(gate_marmux[g]), .PCMUX(pcmux[g]), .ADDR2MUX(addr2mux[g]),
            .ALUK(aluk[g]), .DRMUX(drmux[g]), .SR1MUX(sr1mux[g]), .SR2MUX(sr2mux[g]),
            .ADDR1MUX(addr1mux[g]), .MARMUX(marmux[g]), .MIO_EN(mio_en[g]),
            .Mem_OE(mem_oe[g]), .Mem_WE(mem_we[g])
        );
    end

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic drmux, sr1mux, sr2mux, addr1mux, marmux, mio_en, mem_oe, mem_we;
    } snap_t;

    typedef struct packed {
        int          cycles;
        logic [63:0] oe;
        logic [63:0] we;
        logic [63:0] mdr;
        int          ldreg;
        int          ldpc;
    } exp_t;

    typedef struct {
        int          k;
        logic [15:0] instr;
        logic        b;
        int          cycles;
        int          oe_n;
        int          we_n;
        int          ldreg;
        int          ldpc;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;
    int gate_viol = 0;

    snap_t       snaps [64];
    int          m_cycles;
    logic [63:0] m_oe, m_we, m_mdr;
    int          m_ldreg, m_ldpc;
    snap_t       idle;
    vec_t        tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic snap_t grab(input int k);
        snap_t s;
        s.ld_mar = ld_mar[k];   s.ld_mdr = ld_mdr[k];     s.ld_ir = ld_ir[k];     s.ld_ben = ld_ben[k];
        s.ld_cc = ld_cc[k];     s.ld_reg = ld_reg[k];     s.ld_pc = ld_pc[k];     s.ld_led = ld_led[k];
        s.gate_pc = gate_pc[k]; s.gate_mdr = gate_mdr[k]; s.gate_alu = gate_alu[k];
        s.gate_marmux = gate_marmux[k];
        s.pcmux = pcmux[k];     s.addr2mux = addr2mux[k]; s.aluk = aluk[k];
        s.drmux = drmux[k];     s.sr1mux = sr1mux[k];     s.sr2mux = sr2mux[k];
        s.addr1mux = addr1mux[k]; s.marmux = marmux[k];   s.mio_en = mio_en[k];
        s.mem_oe = mem_oe[k];   s.mem_we = mem_we[k];
        return s;
    endfunction

    function automatic logic at_fetch1(input int k);
        return gate_pc[k] && ld_mar[k];
    endfunction

    // Reference: cycle positions counted from FETCH1 (index 0) by instruction class.
    function automatic exp_t model(input logic [3:0] op, input logic b, input int mw);
        exp_t        e;
        int          base;
        logic [63:0] ones;
        ones    = (64'd1 << mw) - 64'd1;
        base    = mw + 2;                 // index of DECODE
        e.oe    = ones << 1;
        e.mdr   = 64'd1 << mw;
        e.we    = '0;
        e.ldreg = 0;
        e.ldpc  = 1;
        case (op)
            4'h1, 4'h5, 4'h9: begin e.cycles = base + 2; e.ldreg = 1; end
            4'h0: begin e.cycles = b ? base + 3 : base + 2; e.ldpc = b ? 2 : 1; end
            4'hC: begin e.cycles = base + 2; e.ldpc = 2; end
            4'h4: begin e.cycles = base + 3; e.ldpc = 2; e.ldreg = 1; end
            4'h6: begin
                e.cycles = base + mw + 3;
                e.oe    |= ones << (base + 2);
                e.mdr   |= 64'd1 << (base + 1 + mw);
                e.ldreg  = 1;
            end
            4'h7: begin
                e.cycles = base + mw + 3;
                e.mdr   |= 64'd1 << (base + 2);
                e.we     = ones << (base + 3);
            end
            default: e.cycles = base + 1;
        endcase
        return e;
    endfunction

    task automatic wait_fetch1(input int k);
        int guard;
        guard = 0;
        while (!at_fetch1(k) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("fetch1_reached", 64'(guard < 200), 64'd1);
    endtask

    // Run one instruction on instance k from FETCH1 to the next FETCH1.
    task automatic run_instr(input int k, input logic [15:0] instr, input logic b);
        wait_fetch1(k);
        ir[k]   = instr;
        ben[k]  = b;
        run[k]  = 1'($urandom_range(0, 1));
        cont[k] = 1'($urandom_range(0, 1));
        m_cycles = 0; m_oe = '0; m_we = '0; m_mdr = '0; m_ldreg = 0; m_ldpc = 0;
        do begin
            snaps[m_cycles] = grab(k);
            if (!mem_oe[k]) m_oe[m_cycles]  = 1'b1;
            if (!mem_we[k]) m_we[m_cycles]  = 1'b1;
            if (ld_mdr[k])  m_mdr[m_cycles] = 1'b1;
            if (ld_reg[k])  m_ldreg++;
            if (ld_pc[k])   m_ldpc++;
            @(negedge clk);
            m_cycles++;
        end while (!at_fetch1(k) && m_cycles < 60);
        chk("instr_completes", 64'(m_cycles < 60), 64'd1);
    endtask

    // At most one bus driver per cycle, watched on both instances throughout.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if ($countones({gate_pc[k], gate_mdr[k], gate_alu[k], gate_marmux[k]}) > 1)
                gate_viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   k;
        logic [3:0] op;
        logic [15:0] instr;
        logic b;

        idle = '0;
        idle.mem_oe = 1'b1;
        idle.mem_we = 1'b1;

        tbl[0]  = '{0, 16'h1042, 1'b0,  6, 2, 0, 1, 1};
        tbl[1]  = '{0, 16'h5020, 1'b0,  6, 2, 0, 1, 1};
        tbl[2]  = '{0, 16'h927F, 1'b0,  6, 2, 0, 1, 1};
        tbl[3]  = '{0, 16'h0E02, 1'b1,  7, 2, 0, 0, 2};
        tbl[4]  = '{0, 16'h0E02, 1'b0,  6, 2, 0, 0, 1};
        tbl[5]  = '{0, 16'hC1C0, 1'b0,  6, 2, 0, 0, 2};
        tbl[6]  = '{0, 16'h4801, 1'b0,  7, 2, 0, 1, 2};
        tbl[7]  = '{0, 16'h6283, 1'b0,  9, 4, 0, 1, 1};
        tbl[8]  = '{0, 16'h3000, 1'b0,  5, 2, 0, 0, 1};
        tbl[9]  = '{1, 16'h7283, 1'b0, 11, 3, 3, 0, 1};
        tbl[10] = '{1, 16'h6283, 1'b0, 11, 6, 0, 1, 1};
        tbl[11] = '{1, 16'h1042, 1'b0,  7, 3, 0, 1, 1};

        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1; run[i] = 1'b0; cont[i] = 1'b0; ben[i] = 1'b0; ir[i] = 16'h1042;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) chk("reset_outputs", 64'(grab(i)), 64'(idle));
        for (int i = 0; i < 2; i++) reset[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) chk("halted_holds_without_run", 64'(grab(i)), 64'(idle));
        for (int i = 0; i < 2; i++) run[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("run_enters_fetch1", 64'(at_fetch1(i)), 64'd1);
        for (int i = 0; i < 2; i++) run[i] = 1'b0;

        // Table of instruction-level expectations.
        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].k, tbl[i].instr, tbl[i].b);
            chk($sformatf("tbl%0d_cycles", i), 64'(m_cycles), 64'(tbl[i].cycles));
            chk($sformatf("tbl%0d_oe_low", i), 64'($countones(m_oe)), 64'(tbl[i].oe_n));
            chk($sformatf("tbl%0d_we_low", i), 64'($countones(m_we)), 64'(tbl[i].we_n));
            chk($sformatf("tbl%0d_ld_reg", i), 64'(m_ldreg), 64'(tbl[i].ldreg));
            chk($sformatf("tbl%0d_ld_pc", i), 64'(m_ldpc), 64'(tbl[i].ldpc));
        end

        // ADD, MEM_WAIT=2: fetch and execute detail.
        run_instr(0, 16'h1042, 1'b0);
        chk("f1_ld_pc",    64'(snaps[0].ld_pc), 64'd1);
        chk("f1_ld_mar",   64'(snaps[0].ld_mar), 64'd1);
        chk("f1_pcmux",    64'(snaps[0].pcmux), 64'd0);
        chk("f2_oe_mask",  m_oe, 64'b0110);
        chk("f2_mdr_mask", m_mdr, 64'b0100);
        chk("f2_mio_en",   64'(snaps[2].mio_en), 64'd1);
        chk("f3_ld_ir",    64'(snaps[3].ld_ir), 64'd1);
        chk("dec_ld_ben",  64'(snaps[4].ld_ben), 64'd1);
        chk("add_sr2mux",  64'(snaps[5].sr2mux), 64'd0);
        chk("add_aluk",    64'(snaps[5].aluk), 64'd0);
        chk("add_ld_reg",  64'(snaps[5].ld_reg & snaps[5].ld_cc & snaps[5].gate_alu), 64'd1);
        chk("add_sr1mux",  64'(snaps[5].sr1mux), 64'd1);

        run_instr(0, 16'h1062, 1'b0);
        chk("add_imm_sr2mux", 64'(snaps[5].sr2mux), 64'd1);
        run_instr(0, 16'h5020, 1'b0);
        chk("and_aluk", 64'(snaps[5].aluk), 64'd1);
        run_instr(0, 16'h927F, 1'b0);
        chk("not_aluk", 64'(snaps[5].aluk), 64'd2);

        run_instr(0, 16'h0E02, 1'b1);
        chk("br_take_pcmux",    64'(snaps[6].pcmux), 64'd2);
        chk("br_take_addr2mux", 64'(snaps[6].addr2mux), 64'd2);
        chk("br_take_ld_pc",    64'(snaps[6].ld_pc), 64'd1);
        chk("br_take_addr1mux", 64'(snaps[6].addr1mux), 64'd0);
        run_instr(0, 16'h0E02, 1'b0);
        chk("br_chk_no_ld_pc",  64'(snaps[5].ld_pc), 64'd0);

        run_instr(0, 16'h4801, 1'b0);
        chk("jsr1_r7_write", 64'(snaps[5].gate_pc & snaps[5].drmux & snaps[5].ld_reg), 64'd1);
        chk("jsr2_off11",    64'({snaps[6].addr1mux, snaps[6].addr2mux, snaps[6].pcmux}), 64'b0_11_10);
        run_instr(0, 16'h4080, 1'b0);
        chk("jsrr_base",     64'({snaps[6].addr1mux, snaps[6].addr2mux, snaps[6].pcmux}), 64'b1_00_10);
        run_instr(0, 16'hC1C0, 1'b0);
        chk("jmp_base",      64'({snaps[5].addr1mux, snaps[5].addr2mux, snaps[5].pcmux}), 64'b1_00_10);

        // STR, MEM_WAIT=3.
        run_instr(1, 16'h7283, 1'b0);
        chk("str1_marmux",   64'(snaps[6].gate_marmux & snaps[6].ld_mar), 64'd1);
        chk("str2_mio_en",   64'(snaps[7].mio_en), 64'd0);
        chk("str2_ld_mdr",   64'(snaps[7].ld_mdr & snaps[7].gate_alu), 64'd1);
        chk("str2_aluk",     64'(snaps[7].aluk), 64'd3);
        chk("str2_sr1mux",   64'(snaps[7].sr1mux), 64'd0);
        chk("str3_we_mask",  m_we, 64'b111_0000_0000);
        chk("str_oe_mask",   m_oe, 64'b1110);

        run_instr(1, 16'h6283, 1'b0);
        chk("ldr1_addr", 64'({snaps[6].addr1mux, snaps[6].addr2mux}), 64'b1_01);
        chk("ldr3_load", 64'(snaps[11 - 1].gate_mdr & snaps[10].ld_reg & snaps[10].ld_cc), 64'd1);

        // PAUSE on MEM_WAIT=2 instance: PAUSE1 at cycle 5 after FETCH1.
        wait_fetch1(0);
        ir[0] = 16'hD0FF; cont[0] = 1'b0;
        @(negedge clk);
        chk("pause_fetch_no_led", 64'(ld_led[0]), 64'd0);
        repeat (4) @(negedge clk);
        chk("pause1_ld_led", 64'(ld_led[0]), 64'd1);
        repeat (3) @(negedge clk);
        chk("pause1_holds", 64'({ld_led[0], at_fetch1(0)}), 64'b10);
        cont[0] = 1'b1; ir[0] = 16'h3000;
        @(negedge clk);
        chk("pause2_entered", 64'({ld_led[0], at_fetch1(0)}), 64'b00);
        repeat (2) @(negedge clk);
        chk("pause2_holds", 64'({ld_led[0], at_fetch1(0)}), 64'b00);
        cont[0] = 1'b0;
        @(negedge clk);
        chk("pause2_to_fetch1", 64'(at_fetch1(0)), 64'd1);

        // Reset in the second (last) cycle of the LDR2 read.
        run[0] = 1'b0;
        wait_fetch1(0);
        ir[0] = 16'h6283;
        repeat (6) @(negedge clk);
        chk("ldr2_first_oe", 64'({mem_oe[0], ld_mdr[0]}), 64'b00);
        @(negedge clk);
        reset[0] = 1'b1;
        #1;
        chk("reset_cycle_idle", 64'(grab(0)), 64'(idle));
        @(negedge clk);
        chk("reset_halted_idle", 64'(grab(0)), 64'(idle));
        reset[0] = 1'b0;
        @(negedge clk);
        chk("after_reset_halted", 64'(grab(0)), 64'(idle));
        run[0] = 1'b1;
        @(negedge clk);
        chk("restart_fetch1", 64'(at_fetch1(0)), 64'd1);
        run[0] = 1'b0;

        // Random instructions against the reference model.
        for (int n = 0; n < 40; n++) begin
            k = int'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 15));
            if (op == 4'hD) op = 4'h3;
            instr = {op, 12'($urandom)};
            b = 1'($urandom_range(0, 1));
            e = model(op, b, (k == 0) ? 2 : 3);
            run_instr(k, instr, b);
            chk($sformatf("rnd%0d_op%0h_cycles", n, op), 64'(m_cycles), 64'(e.cycles));
            chk($sformatf("rnd%0d_op%0h_oe", n, op), m_oe, e.oe);
            chk($sformatf("rnd%0d_op%0h_we", n, op), m_we, e.we);
            chk($sformatf("rnd%0d_op%0h_mdr", n, op), m_mdr, e.mdr);
            chk($sformatf("rnd%0d_op%0h_ldreg", n, op), 64'(m_ldreg), 64'(e.ldreg));
            chk($sformatf("rnd%0d_op%0h_ldpc", n, op), 64'(m_ldpc), 64'(e.ldpc));
        end

        chk("gate_onehot_violations", 64'(gate_viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
